// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Raster timing bundle between the VGA timing generator and
//                the sprite/background draw stages.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
  logic       pix_en;
  logic       hs;
  logic       vs;
  logic       blank;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       line_start;
  logic       vblank_start;
  logic [7:0] frame_count;

  // Timing generator side: consumes the pixel strobe, drives raster state.
  modport master (
    input  pix_en,
    output hs, vs, blank, DrawX, DrawY, line_start, vblank_start, frame_count
  );

  // Draw-stage side: supplies the pixel strobe, observes raster state.
  modport slave (
    output pix_en,
    input  hs, vs, blank, DrawX, DrawY, line_start, vblank_start, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : 640x480@60 VGA raster generator. Produces hs/vs, the visible
//                region flag, pixel coordinates, line/vblank pulses and a
//                free-running frame counter, all registered and aligned.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_timing_gen_if.master  vif
);

  localparam int         c_H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int         c_V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
  localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
  localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] c_HS_BEG   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] c_VS_BEG   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic       c_SYNC_ACT = SYNC_POL;

  // r_hc/r_vc hold the position that the next enabled edge will present;
  // the output registers below hold the position currently on screen.
  logic [9:0] r_hc;
  logic [9:0] r_vc;

  logic [9:0] r_draw_x;
  logic [9:0] r_draw_y;
  logic       r_blank;
  logic       r_hs;
  logic       r_vs;
  logic       r_line_start;
  logic       r_vblank_start;
  logic [7:0] r_frame_count;

  logic w_h_last;
  logic w_v_last;
  logic w_visible;
  logic w_hs_act;
  logic w_vs_act;
  logic w_line_start;
  logic w_vblank_start;

  assign w_h_last       = (r_hc == c_H_LAST);
  assign w_v_last       = (r_vc == c_V_LAST);
  assign w_visible      = (r_hc < c_H_VIS) && (r_vc < c_V_VIS);
  assign w_hs_act       = (r_hc >= c_HS_BEG) && (r_hc < c_HS_END);
  assign w_vs_act       = (r_vc >= c_VS_BEG) && (r_vc < c_VS_END);
  assign w_line_start   = (r_hc == 10'd0);
  assign w_vblank_start = w_line_start && (r_vc == c_V_VIS);

  // Raster position counters: hc every enabled pixel, vc at end of line.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hc <= 10'd0;
      r_vc <= 10'd0;
    end else if (vif.pix_en) begin
      if (w_h_last) begin
        r_hc <= 10'd0;
        r_vc <= w_v_last ? 10'd0 : r_vc + 10'd1;
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end
  end

  // Output registers: every flag is decoded from the same (hc, vc) that is
  // loaded into DrawX/DrawY, so coordinates and flags never skew.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_draw_x       <= 10'd0;
      r_draw_y       <= 10'd0;
      r_blank        <= 1'b0;
      r_hs           <= ~c_SYNC_ACT;
      r_vs           <= ~c_SYNC_ACT;
      r_line_start   <= 1'b0;
      r_vblank_start <= 1'b0;
      r_frame_count  <= 8'd0;
    end else if (vif.pix_en) begin
      r_draw_x       <= r_hc;
      r_draw_y       <= r_vc;
      r_blank        <= w_visible;
      r_hs           <= w_hs_act ? c_SYNC_ACT : ~c_SYNC_ACT;
      r_vs           <= w_vs_act ? c_SYNC_ACT : ~c_SYNC_ACT;
      r_line_start   <= w_line_start;
      r_vblank_start <= w_vblank_start;
      if (w_vblank_start) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign vif.DrawX        = r_draw_x;
  assign vif.DrawY        = r_draw_y;
  assign vif.blank        = r_blank;
  assign vif.hs           = r_hs;
  assign vif.vs           = r_vs;
  assign vif.line_start   = r_line_start;
  assign vif.vblank_start = r_vblank_start;
  assign vif.frame_count  = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. A default 640x480
//                instance and a tiny active-high-sync instance run side by
//                side against an arithmetic raster model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  typedef struct {
    int hv, hf, hsw, hb;
    int vv, vf, vsw, vb;
    bit pol;
  } cfg_t;

  typedef struct {
    int x, y;
    bit blank, hs, vs, ls, vbs;
    int fc;
  } exp_t;

  logic  vga_clk;
  logic  reset;
  longint n;          // enabled edges seen since reset was last released
  int    checks;
  int    failures;
  cfg_t  c_def;
  cfg_t  c_sml;

  vga_timing_gen_if if_def ();
  vga_timing_gen_if if_sml ();

  vga_timing_gen dut_def (
    .vga_clk (vga_clk),
    .reset   (reset),
    .vif     (if_def.master)
  );

  vga_timing_gen #(
    .H_VISIBLE (6), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .SYNC_POL  (1'b1)
  ) dut_sml (
    .vga_clk (vga_clk),
    .reset   (reset),
    .vif     (if_sml.master)
  );

  // 100 MHz-ish bench clock; absolute rate is irrelevant here.
  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // Raster position after n enabled edges, from the frame geometry alone:
  // edge k (1-based) shows linear pixel k-1 of an endless raster.
  function automatic exp_t model(input cfg_t c, input longint cnt);
    exp_t   e;
    longint ht, vt, idx, pv;
    ht = c.hv + c.hf + c.hsw + c.hb;
    vt = c.vv + c.vf + c.vsw + c.vb;
    if (cnt == 0) begin
      e.x = 0; e.y = 0; e.blank = 1'b0; e.hs = ~c.pol; e.vs = ~c.pol;
      e.ls = 1'b0; e.vbs = 1'b0; e.fc = 0;
      return e;
    end
    idx     = cnt - 1;
    e.x     = int'(idx % ht);
    e.y     = int'((idx / ht) % vt);
    e.blank = (e.x < c.hv) && (e.y < c.vv);
    e.hs    = (e.x >= c.hv + c.hf && e.x < c.hv + c.hf + c.hsw) ? c.pol : ~c.pol;
    e.vs    = (e.y >= c.vv + c.vf && e.y < c.vv + c.vf + c.vsw) ? c.pol : ~c.pol;
    e.ls    = (e.x == 0);
    e.vbs   = (e.x == 0) && (e.y == c.vv);
    pv      = longint'(c.vv) * ht;
    e.fc    = (idx < pv) ? 0 : int'(((idx - pv) / (ht * vt) + 1) % 256);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (edges=%0d)", tag, obs, expv, n);
    end
  endtask

  task automatic chk_inst(input string p, input exp_t e,
                          input logic [9:0] x, input logic [9:0] y,
                          input logic bl, input logic h, input logic v,
                          input logic ls, input logic vbs, input logic [7:0] fc);
    chk({p, ".DrawX"},        32'(x),   32'(e.x));
    chk({p, ".DrawY"},        32'(y),   32'(e.y));
    chk({p, ".blank"},        32'(bl),  32'(e.blank));
    chk({p, ".hs"},           32'(h),   32'(e.hs));
    chk({p, ".vs"},           32'(v),   32'(e.vs));
    chk({p, ".line_start"},   32'(ls),  32'(e.ls));
    chk({p, ".vblank_start"}, 32'(vbs), 32'(e.vbs));
    chk({p, ".frame_count"},  32'(fc),  32'(e.fc));
  endtask

  task automatic check_all();
    chk_inst("def", model(c_def, n), if_def.DrawX, if_def.DrawY, if_def.blank,
             if_def.hs, if_def.vs, if_def.line_start, if_def.vblank_start,
             if_def.frame_count);
    chk_inst("sml", model(c_sml, n), if_sml.DrawX, if_sml.DrawY, if_sml.blank,
             if_sml.hs, if_sml.vs, if_sml.line_start, if_sml.vblank_start,
             if_sml.frame_count);
  endtask

  // One clock: drive the strobe, take the edge, sample 1 time unit later.
  task automatic step(input bit en);
    if_def.pix_en = en;
    if_sml.pix_en = en;
    @(posedge vga_clk);
    #1;
    if (en && !reset) n++;
    check_all();
  endtask

  initial begin
    exp_t   e;
    bit     found;
    longint target;

    c_def    = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    c_sml    = '{6, 1, 2, 1, 4, 1, 1, 1, 1'b1};
    checks   = 0;
    failures = 0;
    n        = 0;
    reset    = 1'b1;
    if_def.pix_en = 1'b1;
    if_sml.pix_en = 1'b1;

    // Held in reset: enabled edges must not move anything.
    repeat (3) step(1'b1);

    // Release and free-run: first line/sync/wrap of the default raster and
    // several whole frames of the small one.
    reset = 1'b0;
    repeat (1700) step(1'b1);

    // Random pixel strobe.
    repeat (3000) step(1'($urandom_range(0, 1)));

    // 1-in-2 strobe as for a 50 MHz pixel clock.
    for (int i = 0; i < 2000; i++) step(i[0] == 1'b0);

    // Small raster: run past the 256th vblank so frame_count wraps to 0.
    target = 40 + 255 * 70 + 5;
    for (int i = 0; i < 30000 && n < target; i++) step(1'b1);
    chk("wrap_budget", 32'(n >= target), 32'd1);

    // Walk to a point where the small instance sits inside both sync pulses.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b1);
      e     = model(c_sml, n);
      found = (e.x == 7) && (e.y == 5);
    end
    chk("sync_point_found", 32'(found), 32'd1);
    chk("sml.hs_before_reset", 32'(if_sml.hs), 32'd1);
    chk("sml.vs_before_reset", 32'(if_sml.vs), 32'd1);

    // Asynchronous reset between clock edges: outputs clear with no edge.
    #3;
    reset = 1'b1;
    #1;
    n = 0;
    check_all();
    repeat (2) step(1'b1);
    reset = 1'b0;
    repeat (40) step(1'($urandom_range(0, 1)));
    repeat (40) step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream raster stage for all sprite/background draw blocks.
- Generates 640x480@60 VGA sync, a visible-region flag `blank`, and the pixel coordinates DrawX/DrawY that every sprite stage uses to address its ROM.
- Also provides a vertical-blank pulse and a free-running frame counter. Game and animation logic use these as their per-frame tick and punch/kick frame index.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low hs/vs)

Ports:
- vga_clk  input  1  pixel-domain clock
- reset  input  1  asynchronous, active-high reset
- pix_en  input  1  pixel advance enable; tie to 1 for a 25 MHz vga_clk, or drive a 1-in-2 strobe for 50 MHz
- hs  output  1  horizontal sync
- vs  output  1  vertical sync
- blank  output  1  1 = inside the visible region (draw); 0 = blanking
- DrawX  output  10  current pixel column
- DrawY  output  10  current pixel row
- line_start  output  1  one-pixel pulse at hc==0
- vblank_start  output  1  one-pixel pulse at hc==0, vc==V_VISIBLE
- frame_count  output  8  frames completed since reset, mod 256

Behaviour:
- Derived totals:
  - H_TOTAL = sum of the four H parameters (800 at defaults).
  - V_TOTAL = sum of the four V parameters (525 at defaults).
- Internal counters:
  - hc: 0..H_TOTAL-1. vc: 0..V_TOTAL-1. Both 10 bits.
  - Counters, and every registered output, update only on posedge vga_clk when pix_en=1. With pix_en=0, all outputs hold, and pulses stay high until the next enabled edge.
  - hc increments each enabled cycle. At hc==H_TOTAL-1, hc wraps to 0 and vc increments.
  - At vc==V_TOTAL-1 together with hc==H_TOTAL-1, vc wraps to 0.
- All outputs are registered and mutually aligned: each output reflects the same (hc, vc) pair.
  - DrawX = hc, DrawY = vc. Values above 639/479 are legal during blanking.
  - blank = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - hs is active when H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751); otherwise hs is inactive.
  - vs is active when V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491); otherwise vs is inactive.
  - "Active" level = SYNC_POL.
  - line_start = (hc==0). vblank_start = (hc==0 && vc==V_VISIBLE).
- frame_count increments by 1 on the enabled edge that produces vblank_start=1, and wraps 255 -> 0.
- Reset (asynchronous, immediate, any point in the frame, including mid-line or mid-sync):
  - hc=0, vc=0, DrawX=0, DrawY=0, frame_count=0.
  - blank=0, line_start=0, vblank_start=0.
  - hs and vs forced to their inactive level.
- First enabled edge after reset release:
  - outputs present (0,0) with blank=1, line_start=1, vblank_start=0.
  - Reset does not increment frame_count.
- Timing relationship: no pipeline skew between coordinates and flags. A downstream ROM read on negedge, with the pixel registered on the next posedge, yields exactly one vga_clk of video latency. Downstream stages absorb that latency; this block does not compensate for it.
- Parameter rule: each parameter must be >= 1, and each total must be <= 1023.

Test Plan:
- Reset release with pix_en=1 -> cycle 1 shows DrawX=0, DrawY=0, blank=1, line_start=1, hs=1, vs=1; cycle 640 shows DrawX=639, blank=1; cycle 641 shows DrawX=640, blank=0.
- Line 0, run 800 enabled cycles -> hs=0 exactly for DrawX 656..751 (96 cycles); after DrawX=799 the next value is DrawX=0, DrawY=1.
- Run one full frame (420000 enabled cycles) -> vs=0 for DrawY 490..491 only; vblank_start pulses once, at (0,480); frame_count goes 0 -> 1; wrap occurs at (799,524) -> (0,0).
- Toggle pix_en every other cycle -> outputs change only on enabled edges; one line takes 1600 vga_clk cycles; line_start stays high for 2 vga_clk cycles.
- Run 256 frames -> frame_count reaches 255 and then wraps to 0 at the 256th vblank_start.
- Assert reset at DrawX=700, DrawY=490 (hs=0, vs=0), asynchronous to vga_clk -> outputs clear immediately, with no clock edge needed: hs=1, vs=1, blank=0, frame_count=0; after release, counting restarts at (0,0).
